seg7_msg_sched: RTL and testbench

Message scheduler for the four-digit seven-segment display. Three requesters (inference result, status, error/debug) each offer a 16-bit value. The block grants the display round-robin, enforces a minimum dwell time per message, decodes the granted value to active-low segment codes, and drives the four code inputs of the display scan driver.

---
 rtl/seg7_msg_sched.sv | 155 +++++++++++++++
 tb/tb_seg7_msg_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_msg_sched.sv
// Display message scheduler. Three requesters share a four-digit seven-segment
// display. Grants are round-robin, each grant holds the display for a minimum dwell.
module seg7_msg_sched #(
    parameter logic [25:0] HOLD_CYC = 26'd50_000_000,
    parameter bit          LZB      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [2:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [7:0]  lb_dn_code,
    output logic [7:0]  lb_up_code,
    output logic [7:0]  hb_dn_code,
    output logic [7:0]  hb_up_code,
    output logic [1:0]  dbg_state
);

    // Handshake: req[i] is a level held until gnt[i] pulses for one cycle;
    // a request is only taken in IDLE or OPEN with clr low, never during SHOW.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  last;
    logic [25:0] cnt;

    logic [1:0]  start_idx;
    logic [1:0]  second_idx;
    logic [1:0]  third_idx;
    logic [1:0]  pick_idx;
    logic [15:0] pick_val;
    logic [31:0] dec_codes;
    logic        blank3;
    logic        blank2;
    logic        blank1;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Rotating priority: search starts just past the last owner.
    always_comb begin
        start_idx  = next_idx(last);
        second_idx = next_idx(start_idx);
        third_idx  = next_idx(second_idx);
        if (req[start_idx])
            pick_idx = start_idx;
        else if (req[second_idx])
            pick_idx = second_idx;
        else
            pick_idx = third_idx;
    end

    always_comb begin
        case (pick_idx)
            2'd0:    pick_val = val0;
            2'd1:    pick_val = val1;
            default: pick_val = val2;
        endcase
    end

    always_comb begin
        blank3    = LZB && (pick_val[15:12] == 4'h0);
        blank2    = blank3 && (pick_val[11:8] == 4'h0);
        blank1    = blank2 && (pick_val[7:4] == 4'h0);
        dec_codes = {blank3 ? 8'hFF : hex_seg(pick_val[15:12]),
                     blank2 ? 8'hFF : hex_seg(pick_val[11:8]),
                     blank1 ? 8'hFF : hex_seg(pick_val[7:4]),
                     hex_seg(pick_val[3:0])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last       <= 2'd2;
            cnt        <= '0;
            gnt        <= '0;
            owner      <= 2'd3;
            busy       <= 1'b0;
            hb_up_code <= 8'hFF;
            hb_dn_code <= 8'hFF;
            lb_up_code <= 8'hFF;
            lb_dn_code <= 8'hFF;
        end else begin
            gnt <= '0;
            if (clr) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                owner      <= 2'd3;
                busy       <= 1'b0;
                hb_up_code <= 8'hFF;
                hb_dn_code <= 8'hFF;
                lb_up_code <= 8'hFF;
                lb_dn_code <= 8'hFF;
            end else begin
                case (state)
                    ST_IDLE, ST_OPEN: begin
                        if (|req) begin
                            gnt   <= 3'b001 << pick_idx;
                            owner <= pick_idx;
                            last  <= pick_idx;
                            {hb_up_code, hb_dn_code, lb_up_code, lb_dn_code} <= dec_codes;
                            cnt   <= HOLD_CYC - 26'd1;
                            busy  <= 1'b1;
                            state <= ST_SHOW;
                        end
                    end
                    ST_SHOW: begin
                        // The edge that sees zero closes the dwell.
                        if (cnt == 26'd0) begin
                            state <= ST_OPEN;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 26'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_seg7_msg_sched.sv
// Bench for seg7_msg_sched: directed scenarios plus random requesters, checked
// against a cycle-count reference model through an expected-grant queue.
module tb_seg7_msg_sched;

    localparam int HOLD = 4;
    localparam int EW   = 98;  // {cycle[31:0], idx[1:0], codes_lzb[31:0], codes_nolzb[31:0]}

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [2:0]  req;
    logic [15:0] val0, val1, val2;

    logic [2:0]  gnt, gnt_b;
    logic [1:0]  owner, owner_b;
    logic        busy, busy_b;
    logic [7:0]  lb_dn, lb_up, hb_dn, hb_up;
    logic [7:0]  lb_dn_b, lb_up_b, hb_dn_b, hb_up_b;
    logic [1:0]  dbg_a, dbg_b;
    logic [31:0] codes_a, codes_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_msg_sched #(.HOLD_CYC(26'(HOLD)), .LZB(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .gnt(gnt), .owner(owner), .busy(busy),
        .lb_dn_code(lb_dn), .lb_up_code(lb_up), .hb_dn_code(hb_dn), .hb_up_code(hb_up),
        .dbg_state(dbg_a)
    );

    seg7_msg_sched #(.HOLD_CYC(26'(HOLD)), .LZB(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .gnt(gnt_b), .owner(owner_b), .busy(busy_b),
        .lb_dn_code(lb_dn_b), .lb_up_code(lb_up_b), .hb_dn_code(hb_dn_b), .hb_up_code(hb_up_b),
        .dbg_state(dbg_b)
    );

    assign codes_a = {hb_up, hb_dn, lb_up, lb_dn};
    assign codes_b = {hb_up_b, hb_dn_b, lb_up_b, lb_dn_b};

    // ---------------- clock / cycle index ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [1:0] pick_rr(input logic [1:0] lst, input logic [2:0] r);
        for (int i = 1; i <= 3; i++) begin
            int c;
            c = (int'(lst) + i) % 3;
            if (r[c]) return 2'(c);
        end
        return 2'd0;
    endfunction

    function automatic logic [31:0] ref_codes(input logic [15:0] v, input bit lzb);
        logic [31:0] r;
        int          nib;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            nib = (int'(v) / (1 << (4 * k))) % 16;
            if (lzb && k > 0 && int'(v) < (1 << (4 * k)))
                r[8*k +: 8] = 8'hFF;
            else
                r[8*k +: 8] = seg_tbl[nib];
        end
        return r;
    endfunction

    function automatic logic [15:0] sel_val(input logic [1:0] i);
        case (i)
            2'd0:    return val0;
            2'd1:    return val1;
            default: return val2;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        logic [2:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Arbitration is allowed once the cycle index reaches m_ready; busy is
    // expected after edge e while e < m_busy_end.
    logic [1:0]  m_last     = 2'd2;
    logic [1:0]  m_owner    = 2'd3;
    int          m_ready    = 0;
    int          m_busy_end = 0;
    logic [31:0] m_codes    = 32'hFFFF_FFFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last     <= 2'd2;
            m_owner    <= 2'd3;
            m_ready    <= 0;
            m_busy_end <= 0;
            m_codes    <= 32'hFFFF_FFFF;
        end else if (clr) begin
            m_owner    <= 2'd3;
            m_busy_end <= cyc;
            m_ready    <= cyc + 1;
            m_codes    <= 32'hFFFF_FFFF;
        end else if (cyc >= m_ready && req != 3'b000) begin
            exp_q.push_back({32'(cyc), pick_rr(m_last, req),
                             ref_codes(sel_val(pick_rr(m_last, req)), 1'b1),
                             ref_codes(sel_val(pick_rr(m_last, req)), 1'b0)});
            m_last     <= pick_rr(m_last, req);
            m_owner    <= pick_rr(m_last, req);
            m_busy_end <= cyc + HOLD;
            m_ready    <= cyc + HOLD + 1;
            m_codes    <= ref_codes(sel_val(pick_rr(m_last, req)), 1'b1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int            mon_e;
    logic [EW-1:0] mon_ent;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_e = cyc - 1;
            if (gnt != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", 64'(gnt), 64'd0);
                end else begin
                    mon_ent = exp_q.pop_front();
                    chk("gnt_id", 64'(gnt), 64'(onehot(mon_ent[65:64])));
                    chk("gnt_b_id", 64'(gnt_b), 64'(onehot(mon_ent[65:64])));
                    chk("gnt_cycle", 64'(mon_e), 64'(mon_ent[97:66]));
                    chk("codes_lzb", 64'(codes_a), 64'(mon_ent[63:32]));
                    chk("codes_nolzb", 64'(codes_b), 64'(mon_ent[31:0]));
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][97:66]) < mon_e) begin
                mon_ent = exp_q.pop_front();
                chk("missing_gnt", 64'(gnt), 64'(onehot(mon_ent[65:64])));
            end
            chk("owner", 64'(owner), 64'(m_owner));
            chk("busy", 64'(busy), 64'(mon_e < m_busy_end));
            chk("codes_held", 64'(codes_a), 64'(m_codes));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        clr   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input logic [2:0] mask, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((gnt & mask) != 3'b000) begin
                at  = cyc - 1;
                req = req & ~gnt;
                return;
            end
            req = req & ~gnt;
        end
        chk("gnt_timeout", 64'(gnt), 64'(mask));
    endtask

    // ---------------- stimulus ----------------
    int         t0, t1, nb;
    int         ord[$];
    int         ord_t[$];
    logic [2:0] rr_once, rr_pend;
    int         exp_ord [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        req   = 3'b000;
        val0  = '0;
        val1  = '0;
        val2  = '0;

        // reset values
        repeat (3) tick();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_owner", 64'(owner), 64'd3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_codes", 64'(codes_a), 64'hFFFF_FFFF);
        rst_n = 1'b1;

        // single request from requester 1
        val1 = 16'h12AF;
        req  = 3'b010;
        wait_gnt(3'b010, 10, t0);
        chk("single_codes", 64'(codes_a), 64'hF9A4_888E);
        chk("single_owner", 64'(owner), 64'd1);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nb++;
            tick();
            if (i == 0) chk("gnt_pulse", 64'(gnt), 64'd0);
        end
        chk("dwell_len", 64'(nb), 64'(HOLD));

        // round-robin fairness, each requester re-raises once
        do_reset();
        val0 = 16'($urandom);
        val1 = 16'($urandom);
        val2 = 16'($urandom);
        req  = 3'b111;
        rr_once = 3'b000;
        rr_pend = 3'b000;
        for (int t = 0; t < 80 && ord.size() < 6; t++) begin
            tick();
            req = req | rr_pend;
            rr_pend = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (gnt[i]) begin
                    ord.push_back(i);
                    ord_t.push_back(cyc - 1);
                    req[i] = 1'b0;
                    if (!rr_once[i]) begin
                        rr_once[i] = 1'b1;
                        rr_pend[i] = 1'b1;
                        case (i)
                            0:       val0 = 16'($urandom);
                            1:       val1 = 16'($urandom);
                            default: val2 = 16'($urandom);
                        endcase
                    end
                end
            end
        end
        chk("rr_count", 64'(ord.size()), 64'd6);
        for (int i = 0; i < ord.size() && i < 6; i++) begin
            chk("rr_order", 64'(ord[i]), 64'(exp_ord[i]));
            if (i > 0) chk("rr_gap", 64'(ord_t[i] - ord_t[i-1]), 64'(HOLD + 1));
        end
        req = 3'b000;
        repeat (HOLD + 2) tick();

        // dwell blocking: requester 2 arrives one cycle after requester 0's grant
        val0 = 16'h5A5A;
        req  = 3'b001;
        wait_gnt(3'b001, 20, t0);
        tick();
        val2   = 16'($urandom);
        req[2] = 1'b1;
        wait_gnt(3'b100, 20, t1);
        chk("dwell_block_gap", 64'(t1 - t0), 64'(HOLD + 1));

        // leading-zero blanking
        val0 = 16'h0007;
        req  = 3'b001;
        wait_gnt(3'b001, 20, t0);
        chk("lzb_0007", 64'(codes_a), 64'hFFFF_FFF8);
        chk("nolzb_0007", 64'(codes_b), 64'hC0C0_C0F8);
        val0 = 16'h0000;
        req  = 3'b001;
        wait_gnt(3'b001, 20, t0);
        chk("lzb_0000", 64'(codes_a), 64'hFFFF_FFC0);

        // clr colliding with a request in OPEN
        for (int i = 0; i < 20 && busy; i++) tick();
        clr = 1'b1;
        req = 3'b001;
        tick();
        chk("clr_no_gnt", 64'(gnt), 64'd0);
        chk("clr_owner", 64'(owner), 64'd3);
        chk("clr_codes", 64'(codes_a), 64'hFFFF_FFFF);
        clr = 1'b0;
        tick();
        chk("clr_then_gnt", 64'(gnt), 64'b001);
        req = 3'b000;

        // asynchronous reset three cycles into a dwell
        for (int i = 0; i < 20 && busy; i++) tick();
        val0 = 16'($urandom);
        req  = 3'b001;
        wait_gnt(3'b001, 20, t0);
        repeat (3) tick();
        chk("busy_pre_reset", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_codes", 64'(codes_a), 64'hFFFF_FFFF);
        chk("async_owner", 64'(owner), 64'd3);
        @(negedge clk);
        val2  = 16'($urandom);
        req   = 3'b100;
        rst_n = 1'b1;
        tick();
        chk("gnt_after_reset", 64'(gnt), 64'b100);
        req = 3'b000;

        // random requesters with occasional clr
        for (int t = 0; t < 600; t++) begin
            tick();
            req = req & ~gnt;
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    case (i)
                        0:       val0 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                        1:       val1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                        default: val2 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                    endcase
                    req[i] = 1'b1;
                end
            end
            clr = ($urandom_range(0, 39) == 0);
        end
        clr = 1'b0;
        req = 3'b000;
        repeat (HOLD + 4) tick();
        chk("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
